// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcodes, FSM state encoding, ALU source/op codes.
// Used by the control FSM and by the ALU and Data stages.
package ctrl_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;

  localparam logic [2:0] OP_3R  = 3'b000;
  localparam logic [2:0] OP_2RI = 3'b001;
  localparam logic [2:0] OP_RI  = 3'b010;
  localparam logic [2:0] OP_L   = 3'b011;
  localparam logic [2:0] OP_UJ  = 3'b100;
  localparam logic [2:0] OP_B   = 3'b101;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_ALU_WB,
    ST_BRANCH,
    ST_JUMP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_RI2,
    CLS_RI,
    CLS_L,
    CLS_UJ,
    CLS_B,
    CLS_ILL
  } opclass_e;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_REG  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_TWO  = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_FUNCT  = 3'd2;

  function automatic opclass_e op_class(input logic [2:0] op);
    case (op)
      OP_3R:   return CLS_R;
      OP_2RI:  return CLS_RI2;
      OP_RI:   return CLS_RI;
      OP_L:    return CLS_L;
      OP_UJ:   return CLS_UJ;
      OP_B:    return CLS_B;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control-unit bus: memory handshake and ALU flag in, datapath/memory controls out.
// master = control unit, slave = datapath/memory side.
interface control_fsm_if;
  import ctrl_pkg::*;

  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  alu_zero;

  logic [DATA_W-1:0]     ir;
  logic [REG_ADDR_W-1:0] input_reg_readA_address;
  logic [REG_ADDR_W-1:0] input_reg_readB_address;
  logic [REG_ADDR_W-1:0] input_reg_write_address;
  logic                  input_reg_write;
  logic                  memToReg;
  logic                  mem_read;
  logic                  mem_write;
  logic                  iord;
  logic                  ir_write;
  logic                  pc_write;
  logic                  pc_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            alu_op;
  logic                  illegal;

  modport master (
    input  mem_ready, mem_rdata, alu_zero,
    output ir, input_reg_readA_address, input_reg_readB_address,
           input_reg_write_address, input_reg_write, memToReg,
           mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, illegal
  );

  modport slave (
    output mem_ready, mem_rdata, alu_zero,
    input  ir, input_reg_readA_address, input_reg_readB_address,
           input_reg_write_address, input_reg_write, memToReg,
           mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, illegal
  );

endinterface

// File: rtl/control_decode.sv
// Combinational IR decode: opcode class, illegal flag and register-file address fields.
// IR[6:4] (ALU funct body) is consumed by the ALU, not here.
module control_decode
  import ctrl_pkg::*;
(
  input  logic [15:7]           ir_regs,
  input  logic [3:0]            ir_op,
  output opclass_e              op_cls,
  output logic                  op_alt,
  output logic                  op_illegal,
  output logic [REG_ADDR_W-1:0] read_a_addr,
  output logic [REG_ADDR_W-1:0] read_b_addr,
  output logic [REG_ADDR_W-1:0] write_addr
);

  always_comb begin
    op_cls      = op_class(ir_op[2:0]);
    op_alt      = ir_op[3];
    op_illegal  = (op_cls == CLS_ILL);
    write_addr  = ir_regs[15:13];
    read_a_addr = ir_regs[12:10];
    read_b_addr = ir_regs[9:7];
    // B-type compares rd-field with rs1-field; sw stores the rd-field register
    if (op_cls == CLS_B) begin
      read_a_addr = ir_regs[15:13];
      read_b_addr = ir_regs[12:10];
    end else if (op_cls == CLS_L && op_alt) begin
      read_b_addr = ir_regs[15:13];
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit + instruction register for the 16-bit processor.
// Optional CTRL_INSTRET_EN adds a retired-instruction counter port instret.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  control_fsm_if.master      bus
`ifdef CTRL_INSTRET_EN
  ,
  output logic [15:0]        instret
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              illegal_q, illegal_d;

  opclass_e          op_cls;
  logic              op_alt;
  logic              op_illegal;

  control_decode u_decode (
    .ir_regs     (ir_q[15:7]),
    .ir_op       (ir_q[3:0]),
    .op_cls      (op_cls),
    .op_alt      (op_alt),
    .op_illegal  (op_illegal),
    .read_a_addr (bus.input_reg_readA_address),
    .read_b_addr (bus.input_reg_readB_address),
    .write_addr  (bus.input_reg_write_address)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          case (op_cls)
            CLS_R:           state_d = ST_EXEC_R;
            CLS_RI2, CLS_RI: state_d = ST_EXEC_I;
            CLS_L:           state_d = ST_MEM_ADDR;
            CLS_B:           state_d = ST_BRANCH;
            CLS_UJ:          state_d = ST_JUMP;
            default:         state_d = ST_FETCH;
          endcase
        end
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_MEM_ADDR:  state_d = op_alt ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (bus.mem_ready) state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

`ifdef CTRL_INSTRET_EN
  logic [15:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q != ST_FETCH && state_d == ST_FETCH)
      instret_d = instret_q + 16'd1;
  end

  assign instret = instret_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
`ifdef CTRL_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
`ifdef CTRL_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end

  assign bus.ir      = ir_q;
  assign bus.illegal = illegal_q;

  // Write strobes are gated by RST_N so an abandoned instruction commits nothing
  always_comb begin
    bus.input_reg_write = 1'b0;
    bus.memToReg        = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.iord            = 1'b0;
    bus.ir_write        = 1'b0;
    bus.pc_write        = 1'b0;
    bus.pc_src          = 1'b0;
    bus.alu_src_a       = SRC_A_PC;
    bus.alu_src_b       = SRC_B_REG;
    bus.alu_op          = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRC_B_TWO;
        bus.ir_write  = bus.mem_ready & RST_N;
        bus.pc_write  = bus.mem_ready & RST_N;
      end
      ST_DECODE: bus.alu_src_b = SRC_B_IMM;
      ST_EXEC_R: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        bus.alu_src_a = (op_cls == CLS_RI) ? SRC_A_ZERO : SRC_A_REG;
        bus.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      ST_MEM_WRITE: begin
        bus.mem_write = RST_N;
        bus.iord      = 1'b1;
      end
      ST_MEM_WB: begin
        bus.input_reg_write = RST_N;
        bus.memToReg        = 1'b1;
      end
      ST_ALU_WB: bus.input_reg_write = RST_N;
      ST_BRANCH: begin
        bus.alu_src_a = SRC_A_REG;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 1'b1;
        bus.pc_write  = (bus.alu_zero ^ op_alt) & RST_N;
      end
      ST_JUMP: begin
        bus.pc_src   = 1'b1;
        bus.pc_write = RST_N;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm; instret checks apply when CTRL_INSTRET_EN is defined.
module tb_control_fsm;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  control_fsm_if bus ();

`ifdef CTRL_INSTRET_EN
  logic [15:0] instret;
`endif

  control_fsm dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus)
`ifdef CTRL_INSTRET_EN
    ,
    .instret (instret)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.alu_zero  = 1'b0;

    // reset state
    #2;
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b1);
    chk("rst_reg_write", bus.input_reg_write, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_ir_write_gated", bus.ir_write, 1'b0);
    chk("rst_pc_write_gated", bus.pc_write, 1'b0);
`ifdef CTRL_INSTRET_EN
    chk("rst_instret", instret, 16'd0);
`endif
    bus.mem_ready = 1'b0;
    #5 RST_N = 1'b1;

    // 3R 0x2900: rd=1 rs1=2 rs2=2, write in the 4th cycle
    bus.mem_rdata = 16'h2900;
    bus.mem_ready = 1'b1;
    #1;
    chk("r_fetch_ir_write", bus.ir_write, 1'b1);
    chk("r_fetch_pc_write", bus.pc_write, 1'b1);
    chk("r_fetch_src_b", bus.alu_src_b, 2'd1);
    chk("r_fetch_iord", bus.iord, 1'b0);
    tick();
    bus.mem_ready = 1'b0;
    chk("r_dec_ir", bus.ir, 16'h2900);
    chk("r_dec_readA", bus.input_reg_readA_address, 3'd2);
    chk("r_dec_readB", bus.input_reg_readB_address, 3'd2);
    chk("r_dec_src_b", bus.alu_src_b, 2'd2);
    chk("r_dec_src_a", bus.alu_src_a, 2'd0);
    chk("r_dec_reg_write", bus.input_reg_write, 1'b0);
    tick();
    chk("r_exec_alu_op", bus.alu_op, 3'd2);
    chk("r_exec_src_a", bus.alu_src_a, 2'd1);
    chk("r_exec_src_b", bus.alu_src_b, 2'd0);
    chk("r_exec_reg_write", bus.input_reg_write, 1'b0);
    tick();
    chk("r_wb_reg_write", bus.input_reg_write, 1'b1);
    chk("r_wb_mem_to_reg", bus.memToReg, 1'b0);
    chk("r_wb_waddr", bus.input_reg_write_address, 3'd1);
    tick();
    chk("r_stall_mem_read", bus.mem_read, 1'b1);
    chk("r_stall_ir_write", bus.ir_write, 1'b0);
    chk("r_stall_reg_write", bus.input_reg_write, 1'b0);
    tick();
    chk("r_stall2_pc_write", bus.pc_write, 1'b0);

    // lw 0x4403 with a 3-cycle MEM_READ stall
    bus.mem_rdata = 16'h4403;
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_fetch_ir_write", bus.ir_write, 1'b1);
    tick();
    bus.mem_ready = 1'b0;
    chk("lw_dec_ir", bus.ir, 16'h4403);
    chk("lw_dec_waddr", bus.input_reg_write_address, 3'd2);
    tick();
    chk("lw_addr_src_a", bus.alu_src_a, 2'd1);
    chk("lw_addr_src_b", bus.alu_src_b, 2'd2);
    chk("lw_addr_alu_op", bus.alu_op, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_stall_mem_read", bus.mem_read, 1'b1);
      chk("lw_stall_iord", bus.iord, 1'b1);
      chk("lw_stall_reg_write", bus.input_reg_write, 1'b0);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h0005;
    bus.alu_zero  = 1'b1;
    #1;
    chk("lw_ready_mem_read", bus.mem_read, 1'b1);
    tick();
    chk("lw_wb_mem_to_reg", bus.memToReg, 1'b1);
    chk("lw_wb_reg_write", bus.input_reg_write, 1'b1);
    chk("lw_wb_waddr", bus.input_reg_write_address, 3'd2);
    chk("lw_wb_mem_read", bus.mem_read, 1'b0);

    // beq 0x0005
    tick();
    chk("beq_fetch_ir_write", bus.ir_write, 1'b1);
    tick();
    chk("beq_dec_pc_write", bus.pc_write, 1'b0);
    tick();
    chk("beq_z1_pc_write", bus.pc_write, 1'b1);
    chk("beq_pc_src", bus.pc_src, 1'b1);
    chk("beq_alu_op", bus.alu_op, 3'd1);
    chk("beq_src_a", bus.alu_src_a, 2'd1);
    chk("beq_src_b", bus.alu_src_b, 2'd0);
    bus.alu_zero = 1'b0;
    #1;
    chk("beq_z0_pc_write", bus.pc_write, 1'b0);

    // bne 0x000D
    bus.mem_rdata = 16'h000D;
    tick();
    tick();
    tick();
    chk("bne_z0_pc_write", bus.pc_write, 1'b1);
    bus.alu_zero = 1'b1;
    #1;
    chk("bne_z1_pc_write", bus.pc_write, 1'b0);

    // sw 0x600B, reset while stalled in MEM_WRITE
    bus.mem_rdata = 16'h600B;
    tick();
    tick();
    chk("sw_dec_readB", bus.input_reg_readB_address, 3'd3);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("sw_mem_write", bus.mem_write, 1'b1);
    chk("sw_iord", bus.iord, 1'b1);
    tick();
    chk("sw_stall_mem_write", bus.mem_write, 1'b1);
    chk("sw_stall_pc_write", bus.pc_write, 1'b0);
    RST_N = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h0006;
    #1;
    chk("mid_rst_mem_write", bus.mem_write, 1'b0);
    chk("mid_rst_ir", bus.ir, 16'h0000);
    chk("mid_rst_reg_write", bus.input_reg_write, 1'b0);
    chk("mid_rst_pc_write", bus.pc_write, 1'b0);
    chk("mid_rst_ir_write", bus.ir_write, 1'b0);
    #2 RST_N = 1'b1;
    #1;
    chk("post_rst_mem_read", bus.mem_read, 1'b1);
    chk("post_rst_iord", bus.iord, 1'b0);
    chk("post_rst_src_b", bus.alu_src_b, 2'd1);
    chk("post_rst_ir_write", bus.ir_write, 1'b1);
`ifdef CTRL_INSTRET_EN
    chk("post_rst_instret", instret, 16'd0);
`endif

    // illegal opcode 3'b110, then a valid 3R
    tick();
    chk("ill_dec_ir", bus.ir, 16'h0006);
    chk("ill_dec_flag", bus.illegal, 1'b0);
    tick();
    chk("ill_flag_set", bus.illegal, 1'b1);
    chk("ill_back_fetch", bus.mem_read, 1'b1);
    bus.mem_rdata = 16'h2900;
    tick();
    tick();
    tick();
    chk("ill_next_reg_write", bus.input_reg_write, 1'b1);
    chk("ill_sticky_wb", bus.illegal, 1'b1);
    bus.mem_rdata = 16'h0006;
    tick();
    chk("ill_sticky_fetch", bus.illegal, 1'b1);

`ifdef CTRL_INSTRET_EN
    tick();
    tick();
    chk("instret_three", instret, 16'd3);
    for (int i = 0; i < 65533; i++) begin
      tick();
      tick();
    end
    chk("instret_wrap", instret, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
